// File: rtl/mcore_pkg.sv
// Shared types and instruction-field constants for the multicycle core.
package mcore_pkg;

  localparam int unsigned INST_W      = 32;
  localparam int unsigned IMM_W       = 14;
  localparam int unsigned OPC_LSB     = 28;
  localparam int unsigned FUNC_LSB    = 24;
  localparam int unsigned RD_LSB      = 19;
  localparam int unsigned RS_LSB      = 14;
  localparam int unsigned RT_LSB      = 9;
  localparam int unsigned OPC_W       = 4;
  localparam int unsigned FUNC_W      = 4;
  localparam int unsigned REG_FIELD_W = 5;

  typedef enum logic [3:0] {
    OP_ALU_R = 4'd0,
    OP_ALU_I = 4'd1,
    OP_LOAD  = 4'd2,
    OP_STORE = 4'd3,
    OP_BEQ   = 4'd4,
    OP_JUMP  = 4'd5,
    OP_HALT  = 4'd15
  } opcode_e;

  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_AND   = 4'd2,
    FN_OR    = 4'd3,
    FN_XOR   = 4'd4,
    FN_SLL   = 4'd5,
    FN_SRL   = 4'd6,
    FN_SRA   = 4'd7,
    FN_SLT   = 4'd8,
    FN_SLTU  = 4'd9,
    FN_PASSB = 4'd10
  } alu_func_e;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

endpackage

// File: rtl/mcore_alu.sv
// Combinational ALU: func selects the operation on A and B.
module mcore_alu
  import mcore_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [FUNC_W-1:0] func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned SHAMT_W = $clog2(DATA_W);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (alu_func_e'(func))
      FN_ADD:   result = a + b;
      FN_SUB:   result = a - b;
      FN_AND:   result = a & b;
      FN_OR:    result = a | b;
      FN_XOR:   result = a ^ b;
      FN_SLL:   result = a << shamt;
      FN_SRL:   result = a >> shamt;
      FN_SRA:   result = DATA_W'($signed(a) >>> shamt);
      FN_SLT:   result = DATA_W'($signed(a) < $signed(b));
      FN_SLTU:  result = DATA_W'(a < b);
      FN_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mcore_multicycle.sv
// Multicycle core sequencing fetch/decode/exec/mem/wb over one shared memory port.
// Define MCORE_BRANCH_EN to build BEQ/JUMP; otherwise opcodes 4 and 5 act as NOP.
module mcore_multicycle
  import mcore_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted
);

  localparam int unsigned RIDX_W = $clog2(NUM_REGS);

  state_e              state, state_nxt;
  logic                mem_req_nxt, mem_we_nxt, halted_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt, pc_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt, alu_result_nxt, wb_data_nxt;
  logic [INST_W-1:0]   inst_nxt;
  logic [DATA_W-1:0]   mdr, mdr_nxt;
  logic                go_fetch, rf_we, xfer;

  logic [DATA_W-1:0]   rf [NUM_REGS];
  opcode_e             opcode;
  logic [RIDX_W-1:0]   rd_idx, rs_idx, rt_idx;
  logic [DATA_W-1:0]   rd_val, rs_val, rt_val, simm, alu_b, alu_out, wb_val;
  logic [FUNC_W-1:0]   alu_func;

  assign xfer   = mem_req && mem_ack;
  assign opcode = opcode_e'(inst[OPC_LSB +: OPC_W]);
  assign rd_idx = inst[RD_LSB +: RIDX_W];
  assign rs_idx = inst[RS_LSB +: RIDX_W];
  assign rt_idx = inst[RT_LSB +: RIDX_W];
  assign rd_val = rf[rd_idx];
  assign rs_val = rf[rs_idx];
  assign rt_val = rf[rt_idx];
  assign simm   = DATA_W'($signed(inst[IMM_W-1:0]));

  // Memory ops reuse the ALU adder for the effective address.
  assign alu_func = (opcode == OP_LOAD || opcode == OP_STORE) ? FUNC_W'(FN_ADD)
                                                              : inst[FUNC_LSB +: FUNC_W];
  assign alu_b    = (opcode == OP_ALU_R) ? rt_val : simm;
  assign wb_val   = (opcode == OP_LOAD) ? mdr : alu_result;

`ifdef MCORE_BRANCH_EN
  // pc already points past the branch, so pc+1+simm of the branch is pc+simm here.
  logic [ADDR_W-1:0] branch_target;
  assign branch_target = pc + simm[ADDR_W-1:0];
`endif

  mcore_alu #(.DATA_W(DATA_W)) u_alu (
    .func   (alu_func),
    .a      (rs_val),
    .b      (alu_b),
    .result (alu_out)
  );

  always_comb begin
    state_nxt      = state;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    pc_nxt         = pc;
    inst_nxt       = inst;
    alu_result_nxt = alu_result;
    wb_data_nxt    = wb_data;
    halted_nxt     = halted;
    mdr_nxt        = mdr;
    rf_we          = 1'b0;
    go_fetch       = 1'b0;

    case (state)
      ST_BOOT: go_fetch = 1'b1;
      ST_FETCH: begin
        if (xfer) begin
          inst_nxt    = mem_rdata[INST_W-1:0];
          pc_nxt      = pc + ADDR_W'(1);
          mem_req_nxt = 1'b0;
          state_nxt   = ST_DECODE;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (opcode)
          OP_ALU_R, OP_ALU_I: begin
            alu_result_nxt = alu_out;
            state_nxt      = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_result_nxt = alu_out;
            mem_req_nxt    = 1'b1;
            mem_we_nxt     = (opcode == OP_STORE);
            mem_addr_nxt   = alu_out[ADDR_W-1:0];
            mem_wdata_nxt  = rd_val;
            state_nxt      = ST_MEM;
          end
          OP_HALT: begin
            halted_nxt = 1'b1;
            state_nxt  = ST_HALT;
          end
`ifdef MCORE_BRANCH_EN
          OP_BEQ: begin
            if (rd_val == rs_val) pc_nxt = branch_target;
            go_fetch = 1'b1;
          end
          OP_JUMP: begin
            pc_nxt   = branch_target;
            go_fetch = 1'b1;
          end
`endif
          default: go_fetch = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (xfer) begin
          mem_req_nxt = 1'b0;
          if (opcode == OP_LOAD) begin
            mdr_nxt   = mem_rdata;
            state_nxt = ST_WB;
          end else begin
            go_fetch = 1'b1;
          end
        end
      end
      ST_WB: begin
        wb_data_nxt = wb_val;
        rf_we       = (rd_idx != '0);
        go_fetch    = 1'b1;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_BOOT;
    endcase

    // Every path into FETCH launches the instruction request at the new pc.
    if (go_fetch) begin
      state_nxt    = ST_FETCH;
      mem_req_nxt  = 1'b1;
      mem_we_nxt   = 1'b0;
      mem_addr_nxt = pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_BOOT;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pc         <= '0;
      inst       <= '0;
      alu_result <= '0;
      wb_data    <= '0;
      halted     <= 1'b0;
      mdr        <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      state      <= state_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      alu_result <= alu_result_nxt;
      wb_data    <= wb_data_nxt;
      halted     <= halted_nxt;
      mdr        <= mdr_nxt;
      if (rf_we) rf[rd_idx] <= wb_val;
    end
  end

endmodule

// File: tb/tb_mcore_multicycle.sv
// Directed bench for mcore_multicycle: runs a small program against a wait-state memory model.
module tb_mcore_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ack, halted;
  logic [15:0] mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata, inst, alu_result, wb_data;

  logic [31:0] mem [256];
  int          n_vec = 0, n_miss = 0;
  int          cyc = 0, wait_cnt = 0, fetch_wait = 0, data_wait = 3, req_after_halt = 0;
  logic        force_ack;

  int unsigned fa_addr[$], fa_cyc[$];
  logic [31:0] fa_wb[$], fa_alu[$];
  int unsigned exp_addr[$], exp_cpi[$];
  logic [31:0] exp_wb[$];

  mcore_multicycle #(.DATA_W(32), .ADDR_W(16), .NUM_REGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .pc         (pc),
    .inst       (inst),
    .alu_result (alu_result),
    .wb_data    (wb_data),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] fn,
                                      input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [13:0] low);
    return {op, fn, rd, rs, low};
  endfunction

  task automatic add_exp(input int unsigned a, input int unsigned c, input logic [31:0] w);
    exp_addr.push_back(a);
    exp_cpi.push_back(c);
    exp_wb.push_back(w);
  endtask

  // Memory responder: programmable wait states, fetches (addr < 0x40) logged on ack.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = '0;
    end else begin
      if (mem_ack) wait_cnt = 0;
      if (mem_req) begin
        if (mem_we) check_eq("store_bus", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0040, 32'd2});
        if (wait_cnt >= ((mem_addr >= 16'h0040) ? data_wait : fetch_wait)) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? 32'd0 : mem[mem_addr[7:0]];
          if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
          else if (mem_addr < 16'h0040) begin
            fa_addr.push_back(mem_addr);
            fa_cyc.push_back(cyc);
            fa_wb.push_back(wb_data);
            fa_alu.push_back(alu_result);
          end
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) if (halted && mem_req) req_after_halt++;

  initial begin
    reset = 1'b0; force_ack = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]  = enc(1, 0, 1, 0, 14'd5);
    mem[1]  = enc(1, 0, 2, 0, 14'h3FFD);
    mem[2]  = enc(0, 0, 3, 1, {5'd2, 9'd0});
    mem[3]  = enc(1, 0, 0, 0, 14'd7);
    mem[4]  = enc(1, 0, 5, 0, 14'd1);
    mem[5]  = enc(3, 0, 3, 0, 14'h40);
    mem[6]  = enc(2, 0, 4, 0, 14'h40);
    mem[7]  = enc(5, 0, 0, 0, 14'd2);
    mem[8]  = enc(5, 0, 0, 0, 14'd3);
    mem[9]  = enc(1, 0, 7, 0, 14'd9);
    mem[10] = enc(4, 0, 1, 1, 14'h3FFD);
    mem[11] = enc(1, 0, 7, 0, 14'h11);
    mem[12] = enc(1, 0, 6, 0, 14'd1);
    mem[13] = enc(1, 5, 1, 6, 14'd31);
    mem[14] = enc(1, 3, 2, 0, 14'd1);
    mem[15] = enc(0, 8, 8, 1, {5'd2, 9'd0});
    mem[16] = enc(0, 9, 9, 1, {5'd2, 9'd0});
    mem[17] = enc(1, 7, 10, 1, 14'd4);
    mem[18] = enc(0, 1, 11, 2, {5'd1, 9'd0});
    mem[19] = enc(1, 4, 12, 1, 14'h1FFF);
    mem[20] = enc(1, 6, 13, 1, 14'd4);
    mem[21] = enc(1, 10, 14, 0, 14'h3FFF);
    mem[22] = enc(15, 0, 0, 0, 14'd0);
    mem[8'h40] = 32'h55;

    // Expected fetch order, cycles per instruction and wb_data after each one.
    add_exp(0, 4, 32'd5); add_exp(1, 4, 32'hFFFFFFFD); add_exp(2, 4, 32'd2);
    add_exp(3, 4, 32'd7); add_exp(4, 4, 32'd1); add_exp(5, 7, 32'd1); add_exp(6, 8, 32'd2);
`ifdef MCORE_BRANCH_EN
    add_exp(7, 3, 32'd2); add_exp(10, 3, 32'd2); add_exp(8, 3, 32'd2);
`else
    add_exp(7, 3, 32'd2); add_exp(8, 3, 32'd2); add_exp(9, 4, 32'd9);
    add_exp(10, 3, 32'd9); add_exp(11, 4, 32'h11);
`endif
    add_exp(12, 4, 32'd1); add_exp(13, 4, 32'h80000000); add_exp(14, 4, 32'd1);
    add_exp(15, 4, 32'd1); add_exp(16, 4, 32'd0); add_exp(17, 4, 32'hF8000000);
    add_exp(18, 4, 32'h80000001); add_exp(19, 4, 32'h80001FFF); add_exp(20, 4, 32'h08000000);
    add_exp(21, 4, 32'hFFFFFFFF); add_exp(22, 0, 32'hFFFFFFFF);

    repeat (3) @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_inst", inst, 0);
    check_eq("rst_alu", alu_result, 0);
    check_eq("rst_wb", wb_data, 0);
    check_eq("rst_halted", halted, 0);

    force_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_eq("boot_req", mem_req, 1);
    check_eq("boot_addr", mem_addr, 0);

    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    check_eq("halt_reached", halted, 1);
    repeat (20) @(negedge clk);
    check_eq("req_after_halt", req_after_halt, 0);
    check_eq("halt_pc", pc, 23);
    check_eq("halt_inst", inst, enc(15, 0, 0, 0, 14'd0));
    check_eq("store_mem", mem[8'h40], 32'd2);

    check_eq("n_fetch", fa_addr.size(), exp_addr.size());
    for (int k = 0; k < fa_addr.size() && k < exp_addr.size(); k++) begin
      check_eq($sformatf("fetch_addr[%0d]", k), fa_addr[k], exp_addr[k]);
      if (k > 0) begin
        check_eq($sformatf("cpi[%0d]", k - 1), fa_cyc[k] - fa_cyc[k-1], exp_cpi[k-1]);
        check_eq($sformatf("wb[%0d]", k - 1), fa_wb[k], exp_wb[k-1]);
        if (fa_addr[k] == 18) check_eq("alu_sra", fa_alu[k], 32'hF8000000);
      end
    end

    // Reset while the store waits in MEM.
    reset = 1'b0;
    data_wait = 30;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 300 && !(mem_req && mem_we); i++) @(negedge clk);
    check_eq("mem_wait_seen", mem_req && mem_we, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_req", mem_req, 0);
    check_eq("abort_pc", pc, 0);
    check_eq("abort_wb", wb_data, 0);

    // Fetch wait states stretch each instruction.
    fetch_wait = 2;
    data_wait = 0;
    fa_addr.delete(); fa_cyc.delete(); fa_wb.delete(); fa_alu.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 200 && fa_addr.size() < 3; i++) @(negedge clk);
    check_eq("fw_n_fetch", fa_addr.size() >= 3, 1);
    if (fa_addr.size() >= 3) begin
      check_eq("fw_cpi", fa_cyc[1] - fa_cyc[0], 6);
      check_eq("fw_wb0", fa_wb[1], 32'd5);
      check_eq("fw_wb1", fa_wb[2], 32'hFFFFFFFD);
      check_eq("fw_addr2", fa_addr[2], 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
